// File: rtl/pulse_shaper_pkg.sv
// rtl/pulse_shaper_pkg.sv - shared state encoding and default counter width for pulse_shaper
package pulse_shaper_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_shaper_if.sv
// rtl/pulse_shaper_if.sv - trigger/config in, shaped pulse/busy/done out
interface pulse_shaper_if #(
  parameter int CNT_W = 8
);
  logic             trig;
  logic [CNT_W-1:0] delay_cfg;
  logic [CNT_W-1:0] width_cfg;
  logic             pulse;
  logic             busy;
  logic             done;

  modport master (
    output trig,
    output delay_cfg,
    output width_cfg,
    input  pulse,
    input  busy,
    input  done
  );

  modport slave (
    input  trig,
    input  delay_cfg,
    input  width_cfg,
    output pulse,
    output busy,
    output done
  );
endinterface

// File: rtl/pulse_shaper_load_down_counter.sv
// rtl/pulse_shaper_load_down_counter.sv - loadable down counter that stops at zero, flags its final count
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == W'(1));

endmodule

// File: rtl/pulse_shaper.sv
// rtl/pulse_shaper.sv - trigger tick to delayed, width-programmable pulse with busy/done
// Optional RETRIGGER_EN: a trigger during the pulse reloads the width counter.
module pulse_shaper
  import pulse_shaper_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           n_rst,
  pulse_shaper_if.slave  bus
);

  state_t           r_state;
  logic [CNT_W-1:0] r_width;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_cfg_width;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_accept;
  logic             w_delay_end;
  logic             w_retrig;
  logic             w_load;
  logic             w_en;
  logic             w_last;

  assign w_cfg_width = (bus.width_cfg == '0) ? CNT_W'(1) : bus.width_cfg;
  assign w_accept    = (r_state == S_IDLE) && bus.trig;
  assign w_delay_end = (r_state == S_DELAY) && w_last;

`ifdef RETRIGGER_EN
  assign w_retrig = (r_state == S_ACTIVE) && bus.trig;
`else
  assign w_retrig = 1'b0;
`endif

  // A zero delay skips the delay phase, so the counter is primed with the width instead.
  always_comb begin
    w_load_val = '0;
    if (w_accept) begin
      w_load_val = (bus.delay_cfg != '0) ? bus.delay_cfg : w_cfg_width;
    end else if (w_delay_end) begin
      w_load_val = r_width;
    end else if (w_retrig) begin
      w_load_val = w_cfg_width;
    end
  end

  assign w_load = w_accept || w_delay_end || w_retrig;
  assign w_en   = (r_state != S_IDLE) && (w_cnt != '0);

  load_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .cnt      (w_cnt),
    .last     (w_last)
  );

  // Outputs trail the state by one edge; done marks the first idle edge after a busy run.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_width <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pulse <= (r_state == S_ACTIVE);
      r_busy  <= (r_state != S_IDLE);
      r_done  <= r_busy && (r_state == S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (bus.trig) begin
            r_width <= w_cfg_width;
            r_state <= (bus.delay_cfg == '0) ? S_ACTIVE : S_DELAY;
          end
        end
        S_DELAY: begin
          if (w_last) begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_last && !w_retrig) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pulse = r_pulse;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_pulse_shaper.sv
// tb/tb_pulse_shaper.sv - vector table, corner sequences and random run against a window model
module tb_pulse_shaper;

  localparam int CW = 8;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  pulse_shaper_if #(.CNT_W(CW)) bus ();

  pulse_shaper #(.CNT_W(CW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a sequence is a set of edge windows; k counts edges since reset.
  int k = 0;
  bit m_valid = 1'b0;
  int m_t0, m_act_start, m_act_end;
  bit exp_p, exp_b, exp_d;

  typedef struct {
    bit trig;
    int d;
    int w;
    bit p;
    bit b;
    bit dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit t, input int d, input int w, input bit p, input bit b, input bit dn);
    vec_t v;
    v.trig = t; v.d = d; v.w = w; v.p = p; v.b = b; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic model_edge(input bit t, input int d, input int w);
    int we;
    we = (w == 0) ? 1 : w;
    exp_d = m_valid && (k == m_act_end + 1);
    if (t) begin
      if (!m_valid || (k > m_act_end)) begin
        m_valid     = 1'b1;
        m_t0        = k;
        m_act_start = k + d + 1;
        m_act_end   = k + d + we;
      end
`ifdef RETRIGGER_EN
      else if ((k >= m_act_start) && (k <= m_act_end)) begin
        m_act_end = k + we;
      end
`endif
    end
    exp_b = m_valid && (k >= m_t0 + 1) && (k <= m_act_end);
    exp_p = m_valid && (k >= m_act_start) && (k <= m_act_end);
  endtask

  task automatic step(input bit t, input int d, input int w);
    bus.trig      = t;
    bus.delay_cfg = CW'(d);
    bus.width_cfg = CW'(w);
    @(posedge clk);
    model_edge(t, d, w);
    k++;
    #1;
  endtask

  task automatic check_model(input string tag, input int idx);
    chk($sformatf("%s%0d_pulse", tag, idx), bus.pulse, exp_p);
    chk($sformatf("%s%0d_busy", tag, idx), bus.busy, exp_b);
    chk($sformatf("%s%0d_done", tag, idx), bus.done, exp_d);
  endtask

  task automatic apply_reset(input string tag);
    n_rst = 1'b0;
    #1;
    chk({tag, "_pulse"}, bus.pulse, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    m_valid = 1'b0;
    k = 0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    int pend;
    bit t;

    // Reset held with trig asserted
    bus.trig = 1'b1;
    bus.delay_cfg = '0;
    bus.width_cfg = CW'(3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold%0d_pulse", i), bus.pulse, 0);
      chk($sformatf("rst_hold%0d_busy", i), bus.busy, 0);
      chk($sformatf("rst_hold%0d_done", i), bus.done, 0);
    end
    bus.trig = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 3);
      chk($sformatf("rst_quiet%0d_busy", i), bus.busy, 0);
      chk($sformatf("rst_quiet%0d_pulse", i), bus.pulse, 0);
    end

    // Basic: d=0 w=3
    add(1,0,3, 0,0,0); add(0,4,4, 1,1,0); add(0,4,4, 1,1,0); add(0,4,4, 1,1,0);
    add(0,4,4, 0,0,1); add(0,0,0, 0,0,0);
    // Delay: d=5 w=2, extra trig at E3 dropped
    add(1,5,2, 0,0,0); add(0,1,1, 0,1,0); add(0,1,1, 0,1,0); add(1,1,1, 0,1,0);
    add(0,1,1, 0,1,0); add(0,1,1, 0,1,0); add(0,1,1, 1,1,0); add(0,1,1, 1,1,0);
    add(0,0,0, 0,0,1); add(0,0,0, 0,0,0);
    // Zero width: d=2 w=0
    add(1,2,0, 0,0,0); add(0,0,0, 0,1,0); add(0,0,0, 0,1,0); add(0,0,0, 1,1,0);
    add(0,0,0, 0,0,1); add(0,0,0, 0,0,0);
    // Back-to-back: d=0 w=2, re-trigger on the done edge
    add(1,0,2, 0,0,0); add(0,3,3, 1,1,0); add(0,3,3, 1,1,0); add(1,0,2, 0,0,1);
    add(0,5,5, 1,1,0); add(0,5,5, 1,1,0); add(0,0,0, 0,0,1); add(0,0,0, 0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].trig, tbl[i].d, tbl[i].w);
      chk($sformatf("vec%0d_pulse", i), bus.pulse, tbl[i].p);
      chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].b);
      chk($sformatf("vec%0d_done", i), bus.done, tbl[i].dn);
    end

    // Trigger during the pulse: extends only with RETRIGGER_EN
`ifdef RETRIGGER_EN
    pend = 7;
`else
    pend = 4;
`endif
    step(1, 0, 4);
    for (int i = 1; i <= 9; i++) begin
      step((i == 3), 0, 4);
      chk($sformatf("retrig_E%0d_pulse", i), bus.pulse, (i <= pend));
      chk($sformatf("retrig_E%0d_busy", i), bus.busy, (i <= pend));
      chk($sformatf("retrig_E%0d_done", i), bus.done, (i == pend + 1));
    end

    // Asynchronous reset while the pulse is high
    step(1, 0, 5);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("midrst_pre_pulse", bus.pulse, 1);
    #2;
    apply_reset("midrst");
    for (int i = 0; i < 8; i++) begin
      step(0, 3, 3);
      chk($sformatf("midrst_after%0d_busy", i), bus.busy, 0);
      chk($sformatf("midrst_after%0d_done", i), bus.done, 0);
    end

    // Random traffic against the window model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset($sformatf("rndrst%0d", i));
      end else begin
        t = ($urandom_range(0, 3) == 0);
        step(t, int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
        check_model("rnd", i);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
